// File: rtl/encoder_playback_scheduler.sv
// encoder_playback_scheduler
//
// Steps through the buffered encoder characters one slot at a time on the
// 0.2 s tick clock. For each slot it loads the character, holds the tone
// window for the character's pattern length, and then inserts an
// inter-character or inter-word gap. Playback stops at the last slot or at
// the first empty slot. With repeat_en held high, playback wraps back to
// slot 0 instead of finishing.
//
// Ports:
//   clk_s02       0.2 s tick clock
//   rst           asynchronous active-high reset
//   start         one-tick pulse: (re)start playback from slot 0
//   abort         one-tick pulse: stop at once, without a done pulse
//   pause         level: freeze state and counter, mute the tone
//   repeat_en     level: wrap to slot 0 after the final slot
//   char_ticks    pattern length of the selected slot (0 = empty slot)
//   char_is_space selected slot holds a space (selects the long gap)
//   slot_onehot   one-hot active slot; 0 when idle or finishing
//   slot_idx      binary active slot index
//   char_strobe   one-tick pulse on the first PLAY tick of a slot
//   tone_en       high across the PLAY window, low while paused
//   busy          high whenever not IDLE
//   done          one-tick pulse after normal completion
module encoder_playback_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int CHAR_GAP  = 10,
    parameter int WORD_GAP  = 20,
    parameter int CNT_W     = 8
) (
    input  logic                 clk_s02,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    input  logic                 repeat_en,
    input  logic [6:0]           char_ticks,
    input  logic                 char_is_space,
    output logic [NUM_SLOTS-1:0] slot_onehot,
    output logic [2:0]           slot_idx,
    output logic                 char_strobe,
    output logic                 tone_en,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_FINISH
    } state_t;

    localparam logic [2:0]       LAST_SLOT = 3'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_GAP - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_GAP - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // Last counter value of the gap, captured when the slot enters PLAY.
    logic [CNT_W-1:0] gap_last;
    logic [CNT_W-1:0] ticks_ext;
    logic [CNT_W-1:0] tick_last;
    logic             in_slot;

    assign ticks_ext = CNT_W'(char_ticks);
    assign tick_last = ticks_ext - CNT_W'(1);

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_s02 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            gap_last    <= '0;
            slot_idx    <= '0;
            char_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Pulses last exactly one tick unless re-asserted below.
            char_strobe <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                // In IDLE this is a no-op, and it also swallows a
                // simultaneous start.
                state    <= S_IDLE;
                cnt      <= '0;
                slot_idx <= '0;
            end else if (start) begin
                state    <= S_LOAD;
                cnt      <= '0;
                slot_idx <= '0;
            end else if (!pause) begin
                case (state)
                    S_IDLE: ;
                    S_LOAD: begin
                        if (ticks_ext == '0) begin
                            state <= S_FINISH;
                        end else begin
                            state       <= S_PLAY;
                            cnt         <= '0;
                            char_strobe <= 1'b1;
                            gap_last    <= char_is_space ? WORD_LAST : CHAR_LAST;
                        end
                    end
                    S_PLAY: begin
                        if (cnt == tick_last) begin
                            state <= S_GAP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (cnt == gap_last) begin
                            cnt <= '0;
                            if (slot_idx == LAST_SLOT) begin
                                state <= S_FINISH;
                            end else begin
                                state    <= S_LOAD;
                                slot_idx <= slot_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_FINISH: begin
                        slot_idx <= '0;
                        if (repeat_en) begin
                            state <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        slot_idx <= '0;
                    end
                endcase
            end
        end
    end

    // Outputs decode directly from the state register; pause only mutes the
    // tone so that the remaining ticks resume audibly on release.
    assign in_slot     = (state == S_LOAD) || (state == S_PLAY) || (state == S_GAP);
    assign slot_onehot = in_slot ? (NUM_SLOTS'(1) << slot_idx) : '0;
    assign tone_en     = (state == S_PLAY) && !pause;
    assign busy        = (state != S_IDLE);

endmodule
